// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the byte/strobe/status outputs.
// master drives the line (transmitter side); slave is the receiver.
interface uart_rx_if;
    logic       i_RX;
    logic [7:0] o_RX_Byte;
    logic       o_RX_DV;
    logic       o_RX_Frame_Err;
    logic       o_RX_Active;

    modport master (
        output i_RX,
        input  o_RX_Byte,
        input  o_RX_DV,
        input  o_RX_Frame_Err,
        input  o_RX_Active
    );

    modport slave (
        input  i_RX,
        output o_RX_Byte,
        output o_RX_DV,
        output o_RX_Frame_Err,
        output o_RX_Active
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit sampled mid-bit, data and stop bits sampled once per bit period.
// Frame results are registered and presented on the outputs one clock after the stop-bit decision.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic     i_Clock,
    input  logic     i_enable,
    uart_rx_if.slave bus
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_TICK = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        RX_START_BIT,
        RX_DATA_BITS,
        RX_STOP_BIT,
        WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  index_q, index_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        sync_q1, rx_s;
    logic [7:0]  byte_q;
    logic        dv_q, err_q;

    // Synchronizer resets to the idle (high) level so release never looks like a start edge.
    always_ff @(posedge i_Clock or negedge i_enable) begin
        if (!i_enable) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so both flops sample the pre-edge values and form a true 2-stage chain.
            sync_q1 <= bus.i_RX;
            rx_s    <= sync_q1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_enable) begin
        if (!i_enable) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                index_d = '0;
                if (!rx_s) state_d = RX_START_BIT;
            end

            RX_START_BIT: begin
                if (count_q == HALF_TICK) begin
                    count_d = '0;
                    state_d = rx_s ? IDLE : RX_DATA_BITS;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end

            RX_DATA_BITS: begin
                if (count_q == LAST_TICK) begin
                    count_d          = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q == 3'd7) begin
                        index_d = '0;
                        state_d = RX_STOP_BIT;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end

            RX_STOP_BIT: begin
                if (count_q == LAST_TICK) begin
                    count_d = '0;
                    if (rx_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end

            // A held-low (break) line parks here until it goes high again.
            WAIT_IDLE: begin
                count_d = '0;
                if (rx_s) state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
                index_d = '0;
            end
        endcase
    end

    // Byte only moves on a good frame, so it holds across false starts and framing errors.
    always_ff @(posedge i_Clock or negedge i_enable) begin
        if (!i_enable) begin
            byte_q <= '0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dv_q  <= done_q;
            err_q <= ferr_q;
            if (done_q) byte_q <= shift_q;
        end
    end

    assign bus.o_RX_Byte      = byte_q;
    assign bus.o_RX_DV        = dv_q;
    assign bus.o_RX_Frame_Err = err_q;
    assign bus.o_RX_Active    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: line-level frames are generated with exact or skewed bit times,
// the expected byte/error and its output cycle are queued, and a negedge monitor checks each pulse.
`timescale 1ns/1ps
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line [4];
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus0 ();
    uart_rx_if bus1 ();
    uart_rx_if bus2 ();
    uart_rx_if bus3 ();

    assign bus0.i_RX = rx_line[0];
    assign bus1.i_RX = rx_line[1];
    assign bus2.i_RX = rx_line[2];
    assign bus3.i_RX = rx_line[3];

    uart_rx #(.CLKS_PER_BIT(16))  dut0 (.i_Clock(clk), .i_enable(rst_n), .bus(bus0));
    uart_rx #(.CLKS_PER_BIT(4))   dut1 (.i_Clock(clk), .i_enable(rst_n), .bus(bus1));
    uart_rx #(.CLKS_PER_BIT(5))   dut2 (.i_Clock(clk), .i_enable(rst_n), .bus(bus2));
    uart_rx #(.CLKS_PER_BIT(434)) dut3 (.i_Clock(clk), .i_enable(rst_n), .bus(bus3));

    typedef struct packed {
        logic        is_err;
        logic [7:0]  data;
        logic [31:0] cycle;
    } exp_t;

    exp_t       exp_q [4][$];
    logic [7:0] last_good [4];
    int         errors = 0;
    int         checks = 0;

    function automatic int cpb_of(input int idx);
        case (idx)
            0:       return 16;
            1:       return 4;
            2:       return 5;
            default: return 434;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every DV or error pulse must match the oldest expectation for that receiver.
    task automatic watch(input int idx, input logic dv, input logic err, input logic [7:0] b);
        exp_t e;
        if (dv || err) begin
            check($sformatf("dut%0d_dv_err_exclusive", idx), 32'(dv & err), 32'd0);
            check($sformatf("dut%0d_pulse_expected", idx), 32'(exp_q[idx].size() != 0), 32'd1);
            if (exp_q[idx].size() != 0) begin
                e = exp_q[idx].pop_front();
                check($sformatf("dut%0d_pulse_kind", idx), 32'(err), 32'(e.is_err));
                check($sformatf("dut%0d_byte", idx), 32'(b), 32'(e.data));
                check($sformatf("dut%0d_pulse_cycle", idx), cyc, e.cycle);
            end
        end
    endtask

    always @(negedge clk) begin
        watch(0, bus0.o_RX_DV, bus0.o_RX_Frame_Err, bus0.o_RX_Byte);
        watch(1, bus1.o_RX_DV, bus1.o_RX_Frame_Err, bus1.o_RX_Byte);
        watch(2, bus2.o_RX_DV, bus2.o_RX_Frame_Err, bus2.o_RX_Byte);
        watch(3, bus3.o_RX_DV, bus3.o_RX_Frame_Err, bus3.o_RX_Byte);
    end

    // Drives one 8N1 frame; with align=0 the caller must already sit 3 ns after a rising edge.
    task automatic send(input int idx, input logic [7:0] data, input bit stop_ok,
                        input real skew, input bit align);
        int   c;
        real  bit_ns;
        exp_t e;
        c      = cpb_of(idx);
        bit_ns = real'(c) * 10.0 * (1.0 + skew);
        if (align) begin
            @(posedge clk);
            #3;
        end
        e.is_err = !stop_ok;
        e.cycle  = cyc + 1 + 4 + (c - 1) / 2 + 9 * c;
        if (stop_ok) last_good[idx] = data;
        e.data = last_good[idx];
        exp_q[idx].push_back(e);
        rx_line[idx] = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_line[idx] = data[i];
            #(bit_ns);
        end
        rx_line[idx] = stop_ok;
        #(bit_ns);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte"},   32'(bus0.o_RX_Byte),      32'd0);
        check({tag, "_dv"},     32'(bus0.o_RX_DV),        32'd0);
        check({tag, "_err"},    32'(bus0.o_RX_Frame_Err), 32'd0);
        check({tag, "_active"}, 32'(bus0.o_RX_Active),    32'd0);
    endtask

    initial begin
        logic [7:0] b;
        real        skews [3];
        skews = '{-0.02, 0.0, 0.02};
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_line[i]   = 1'b1;
            last_good[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, then two frames with no gap between stop and start.
        send(0, 8'hA5, 1'b1, 0.0, 1'b1);
        repeat (10) @(negedge clk);
        send(0, 8'h00, 1'b1, 0.0, 1'b1);
        send(0, 8'hFF, 1'b1, 0.0, 1'b0);
        repeat (10) @(negedge clk);

        // Five-clock low glitch is rejected at the mid-start sample.
        @(posedge clk);
        #3 rx_line[0] = 1'b0;
        #50 rx_line[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_active", 32'(bus0.o_RX_Active), 32'd0);
        check("glitch_byte_held", 32'(bus0.o_RX_Byte), 32'(last_good[0]));

        // Framing error followed by a 100-clock break, then a good frame.
        send(0, 8'h3C, 1'b0, 0.0, 1'b1);
        repeat (100) @(negedge clk);
        check("break_active", 32'(bus0.o_RX_Active), 32'd1);
        check("break_byte_held", 32'(bus0.o_RX_Byte), 32'(last_good[0]));
        rx_line[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("break_release_active", 32'(bus0.o_RX_Active), 32'd0);
        send(0, 8'h81, 1'b1, 0.0, 1'b1);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 4 of 0x5A; the partial byte must vanish.
        b = 8'h5A;
        @(posedge clk);
        #3 rx_line[0] = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            rx_line[0] = b[i];
            #160;
        end
        rx_line[0] = b[4];
        #80 rst_n = 1'b0;
        #1 check_all_zero("midframe_reset");
        for (int i = 0; i < 4; i++) last_good[i] = 8'h00;
        rx_line[0] = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("held_reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(0, 8'h12, 1'b1, 0.0, 1'b1);
        repeat (10) @(negedge clk);

        // Random traffic, sometimes back-to-back, occasionally with a bad stop bit.
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send(0, b, 1'b0, 0.0, 1'b1);
                rx_line[0] = 1'b1;
                repeat (6) @(negedge clk);
            end else begin
                send(0, b, 1'b1, 0.0, 1'($urandom_range(0, 1)));
            end
        end
        repeat (20) @(negedge clk);

        // Bit-rate sweep with +/-2% transmitter skew.
        for (int idx = 1; idx < 4; idx++) begin
            for (int s = 0; s < 3; s++) begin
                send(idx, 8'h55, 1'b1, skews[s], 1'b1);
                repeat (cpb_of(idx)) @(negedge clk);
                send(idx, 8'($urandom), 1'b1, skews[s], 1'b1);
                repeat (cpb_of(idx)) @(negedge clk);
            end
        end

        // Bounded drain: anything still queued never appeared on the outputs.
        for (int t = 0; t < 2000; t++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
            @(negedge clk);
        end
        for (int idx = 0; idx < 4; idx++) begin
            check($sformatf("dut%0d_all_pulses_seen", idx), 32'(exp_q[idx].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per UART bit = f(i_Clock)/baud; legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port i_enable  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_RX  input  1  serial line, asynchronous to i_Clock, idle high.
REQ-005 SHALL have port o_RX_Byte  output  8  last correctly framed byte, LSB first on the line.
REQ-006 SHALL have port o_RX_DV  output  1  one-cycle pulse, o_RX_Byte newly valid.
REQ-007 SHALL have port o_RX_Frame_Err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port o_RX_Active  output  1  high while a frame is in progress.

Function
REQ-009 SHALL pass i_RX through a 2-flop synchronizer; all decisions use the second flop output (rx_s).
REQ-010 SHALL use a bit counter of at least 16 bits, a 3-bit bit index and an 8-bit shift register.
REQ-011 SHALL implement states IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, WAIT_IDLE.
REQ-012 IDLE: counter and index cleared, o_RX_Active low; rx_s=0 -> RX_START_BIT, o_RX_Active high.
REQ-013 RX_START_BIT: counter increments each clock until counter = (CLKS_PER_BIT-1)/2 (integer division); at that clock rx_s=0 -> RX_DATA_BITS with counter cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-014 RX_DATA_BITS: counter increments until CLKS_PER_BIT-1; at that clock rx_s is stored at bit position index, counter cleared; index<7 -> index+1, stay; index=7 -> index cleared, RX_STOP_BIT.
REQ-015 RX_STOP_BIT: at counter = CLKS_PER_BIT-1, rx_s=1 -> o_RX_Byte loaded from shift register, o_RX_DV high for exactly one clock, -> IDLE.
REQ-016 RX_STOP_BIT: at counter = CLKS_PER_BIT-1, rx_s=0 -> o_RX_Frame_Err high one clock, o_RX_Byte unchanged, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: o_RX_Active stays high; rx_s=1 -> IDLE with o_RX_Active low, so a held-low (break) line never starts a new frame.
REQ-018 Edge 0 is the first rising edge sampling i_RX low. o_RX_DV SHALL be high after edge 4 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT (155 for CLKS_PER_BIT=16).
REQ-019 o_RX_DV and o_RX_Frame_Err SHALL never be high in the same cycle and SHALL default low every cycle not named above.
REQ-020 o_RX_Byte SHALL hold its value between valid frames and after false starts and framing errors.
REQ-021 A new start bit SHALL be accepted on the clock immediately after returning to IDLE (back-to-back frames, no idle gap beyond the stop bit).
REQ-022 An undefined state encoding SHALL go to IDLE on the next clock.

Reset
REQ-023 i_enable low SHALL immediately force state IDLE, counter 0, index 0, shift register 0, synchronizer flops 1, o_RX_Byte 0x00, o_RX_DV 0, o_RX_Frame_Err 0, o_RX_Active 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte with no DV or error pulse; after release, reception restarts only on a fresh falling edge seen by rx_s.

Verification (CLKS_PER_BIT=16)
REQ-025 Send 0xA5, 8N1 at 16 clocks/bit -> o_RX_DV single pulse after edge 155, o_RX_Byte=0xA5, o_RX_Frame_Err never high.
REQ-026 Send 0x00, then 0xFF back-to-back with no gap -> two DV pulses 160 clocks apart; bytes 0x00 then 0xFF.
REQ-027 Drive i_RX low for 5 clocks, then high -> return to IDLE, no DV or error pulse; o_RX_Byte keeps its prior value.
REQ-028 Send 0x3C with stop bit low, then hold the line low 100 clocks, then high -> one o_RX_Frame_Err pulse, no DV; o_RX_Active stays high until the line returns high; o_RX_Byte unchanged; a following 0x81 is received correctly.
REQ-029 Assert i_enable low during data bit 4 of 0x5A, release, send 0x12 -> no pulse for 0x5A; all outputs 0 during reset; o_RX_Byte=0x12 with one DV.
REQ-030 Sweep CLKS_PER_BIT in {4, 5, 434}; send 0x55 with ±2% baud skew -> byte received correctly, DV timing per REQ-018.
